seq_adder: RTL

- Multi-cycle parametrised binary adder/subtractor for the datapath lab series.
- Successor to the single-bit half-adder cell: processes a WIDTH-bit operand pair CHUNK bits per clock.
- Internal state: a carry flip-flop and shift registers.
- Start/busy/done handshake, so a controller FSM can issue one operation and wait for completion.

---
 rtl/seq_adder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seq_adder.sv
// seq_adder: multi-cycle binary adder/subtractor that consumes a WIDTH-bit operand pair
// CHUNK bits per clock, LSB chunk first. One operation takes N = WIDTH/CHUNK compute cycles,
// followed by a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset (priority over everything, aborts an operation)
//   start  request a new operation (accepted in IDLE or DONE)
//   a, b   operands (unsigned or two's complement)
//   cin    carry-in, used only when sub=0
//   sub    0: a+b+cin, 1: a-b computed as a+~b+1
//   busy   high while the operation is computing
//   done   one-cycle pulse marking a valid result
//   sum    result, assembled LSB chunk first from the top
//   cout   final carry-out (for sub=1, 1 means no borrow)
//   ovf    signed overflow: carry into MSB XOR carry out of MSB
module seq_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_adder: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  // Ripple chain over the current chunk; c[i] is the carry into bit i of the chunk.
  logic [CHUNK:0]         c;
  logic [CHUNK-1:0]       prop;
  logic [CHUNK-1:0]       chunk_sum;
  logic [WIDTH+CHUNK-1:0] sum_wide;

  always_comb begin
    c[0] = carry_q;
    for (int i = 0; i < int'(CHUNK); i++) begin
      // Two half-adder stages per bit: (a,b) then (partial sum, carry-in).
      prop[i]      = a_q[i] ^ b_q[i];
      chunk_sum[i] = prop[i] ^ c[i];
      c[i+1]       = (a_q[i] & b_q[i]) | (prop[i] & c[i]);
    end
  end

  // New chunk enters at the top; after N chunks the first one has reached bit 0.
  assign sum_wide = {chunk_sum, sum_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StRun: begin
        sum_d   = sum_wide[WIDTH+CHUNK-1:CHUNK];
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = c[CHUNK];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          cout_d  = c[CHUNK];
          ovf_d   = c[CHUNK] ^ c[CHUNK-1];
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      // DONE behaves as IDLE so a held start gives back-to-back operations.
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
